// File: rtl/router_pkt_reg.sv
`default_nettype none
// ============================================================================
// Module   : router_pkt_reg
// Purpose  : Input-side register block of the 1x3 router. It captures the
//            packet header and streams header, payload and parity towards the
//            selected output FIFO with an explicit write strobe. Bytes that
//            arrive while that FIFO is full are parked in a small skid buffer.
//            It also checks XOR parity, payload length and skid overflow.
// Ports    : clock, resetn           - clock, synchronous active-low reset
//            i_pkt_valid, i_data_in  - incoming byte stream (pkt_valid low on parity)
//            i_fifo_full             - selected output FIFO is full
//            i_detect_add .. i_rst_int_reg - FSM state decodes (one-hot or none)
//            o_dout, o_dout_wr       - byte to output FIFO and its write enable
//            o_skid_empty, o_skid_count - skid buffer occupancy (post-edge)
//            o_low_pkt_valid         - parity byte seen in this packet
//            o_parity_done           - parity byte has been written to o_dout
//            o_err, o_len_err, o_ovf_err - parity / length / overflow errors
// Revision : 1.0 - initial parametrised release
// ============================================================================
module router_pkt_reg #(
    parameter int DW         = 8,
    parameter int SKID_DEPTH = 2
) (
    input  logic                              clock,
    input  logic                              resetn,
    input  logic                              i_pkt_valid,
    input  logic [DW-1:0]                     i_data_in,
    input  logic                              i_fifo_full,
    input  logic                              i_detect_add,
    input  logic                              i_lfd_state,
    input  logic                              i_ld_state,
    input  logic                              i_laf_state,
    input  logic                              i_rst_int_reg,
    output logic [DW-1:0]                     o_dout,
    output logic                              o_dout_wr,
    output logic                              o_skid_empty,
    output logic [$clog2(SKID_DEPTH+1)-1:0]   o_skid_count,
    output logic                              o_low_pkt_valid,
    output logic                              o_parity_done,
    output logic                              o_err,
    output logic                              o_len_err,
    output logic                              o_ovf_err
);

    localparam int c_CNT_W = $clog2(SKID_DEPTH + 1);
    localparam int c_PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
    localparam int c_LEN_W = DW - 2;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [DW-1:0]      r_hdr;
    logic [DW-1:0]      r_dout;
    logic               r_dout_wr;
    logic [DW-1:0]      r_skid_data [SKID_DEPTH];
    logic [SKID_DEPTH-1:0] r_skid_last;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_skid_empty;
    logic [DW-1:0]      r_int_parity;
    logic [DW-1:0]      r_pkt_parity;
    logic [c_LEN_W-1:0] r_pay_cnt;
    logic               r_low_pkt_valid;
    logic               r_parity_done;
    logic               r_err;
    logic               r_len_err;
    logic               r_ovf_err;

    // ------------------------------------------------------------------
    // Skid control
    // ------------------------------------------------------------------
    logic               w_pop;
    logic               w_direct;
    logic               w_push_req;
    logic               w_full;
    logic               w_drop;
    logic               w_push;
    logic               w_accept;
    logic [c_CNT_W-1:0] w_count_next;
    logic [DW-1:0]      w_head_data;
    logic               w_head_last;

    function automatic logic [c_PTR_W-1:0] f_ptr_inc(input logic [c_PTR_W-1:0] p);
        if (p == c_PTR_W'(SKID_DEPTH - 1)) begin
            return '0;
        end
        return p + c_PTR_W'(1);
    endfunction

    always_comb begin
        w_head_data  = r_skid_data[r_rptr];
        w_head_last  = r_skid_last[r_rptr];
        w_full       = (r_count == c_CNT_W'(SKID_DEPTH));
        // Header output has top priority; skid drains before fresh data so
        // byte order on o_dout always matches arrival order.
        w_pop        = !i_lfd_state && (i_laf_state || i_ld_state) &&
                       !i_fifo_full && !r_skid_empty;
        w_direct     = !i_lfd_state && i_ld_state && !i_fifo_full && r_skid_empty;
        // A byte must be parked whenever it cannot go straight out: either the
        // FIFO is full or older bytes are still waiting in the skid.
        w_push_req   = !i_lfd_state && i_ld_state && (i_fifo_full || !r_skid_empty);
        // A full skid that pops in the same cycle frees its slot: no drop.
        w_drop       = w_push_req && w_full && !w_pop;
        w_push       = w_push_req && !w_drop;
        w_accept     = w_direct || w_push;
        w_count_next = r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
    end

    // ------------------------------------------------------------------
    // Skid buffer storage (circular)
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!resetn) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                r_skid_data[i] <= '0;
            end
            r_skid_last  <= '0;
            r_rptr       <= '0;
            r_wptr       <= '0;
            r_count      <= '0;
            r_skid_empty <= 1'b1;
        end else begin
            if (w_push) begin
                r_skid_data[r_wptr] <= i_data_in;
                r_skid_last[r_wptr] <= !i_pkt_valid;
                r_wptr              <= f_ptr_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= f_ptr_inc(r_rptr);
            end
            r_count      <= w_count_next;
            r_skid_empty <= (w_count_next == '0);
        end
    end

    // ------------------------------------------------------------------
    // Output byte path
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_dout        <= '0;
            r_dout_wr     <= 1'b0;
            r_parity_done <= 1'b0;
        end else begin
            r_dout_wr <= 1'b0;
            if (i_detect_add) begin
                r_parity_done <= 1'b0;
            end
            if (i_lfd_state) begin
                r_dout    <= r_hdr;
                r_dout_wr <= 1'b1;
            end else if (w_pop) begin
                r_dout    <= w_head_data;
                r_dout_wr <= 1'b1;
                if (w_head_last) begin
                    r_parity_done <= 1'b1;
                end
            end else if (w_direct) begin
                r_dout    <= i_data_in;
                r_dout_wr <= 1'b1;
                if (!i_pkt_valid) begin
                    r_parity_done <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Header, parity, length and error tracking
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_hdr           <= '0;
            r_int_parity    <= '0;
            r_pkt_parity    <= '0;
            r_pay_cnt       <= '0;
            r_low_pkt_valid <= 1'b0;
            r_err           <= 1'b0;
            r_len_err       <= 1'b0;
            r_ovf_err       <= 1'b0;
        end else begin
            if (i_detect_add && i_pkt_valid) begin
                r_hdr <= i_data_in;
            end

            if (i_detect_add) begin
                r_int_parity <= '0;
                r_pkt_parity <= '0;
                r_pay_cnt    <= '0;
                r_ovf_err    <= 1'b0;
            end else begin
                if (i_lfd_state && i_pkt_valid) begin
                    r_int_parity <= r_int_parity ^ r_hdr;
                end else if (w_accept && i_pkt_valid) begin
                    r_int_parity <= r_int_parity ^ i_data_in;
                end
                if (w_accept && i_pkt_valid) begin
                    r_pay_cnt <= r_pay_cnt + c_LEN_W'(1);
                end
                if (w_accept && !i_pkt_valid) begin
                    r_pkt_parity <= i_data_in;
                end
                if (w_drop) begin
                    r_ovf_err <= 1'b1;
                end
            end

            if (i_rst_int_reg) begin
                r_low_pkt_valid <= 1'b0;
            end else if (i_ld_state && !i_pkt_valid) begin
                r_low_pkt_valid <= 1'b1;
            end

            if (i_rst_int_reg && !i_pkt_valid) begin
                r_err     <= (r_int_parity != r_pkt_parity);
                r_len_err <= (r_pay_cnt != r_hdr[DW-1:2]);
            end
        end
    end

    assign o_dout          = r_dout;
    assign o_dout_wr       = r_dout_wr;
    assign o_skid_empty    = r_skid_empty;
    assign o_skid_count    = r_count;
    assign o_low_pkt_valid = r_low_pkt_valid;
    assign o_parity_done   = r_parity_done;
    assign o_err           = r_err;
    assign o_len_err       = r_len_err;
    assign o_ovf_err       = r_ovf_err;

endmodule
`default_nettype wire

// File: tb/tb_router_pkt_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_router_pkt_reg
// Purpose  : Self-checking bench for router_pkt_reg (DW=8, SKID_DEPTH=2).
//            Expected output bytes are queued as stimulus is driven and
//            compared whenever the design raises its write strobe.
// Revision : 1.0 - initial release
// ============================================================================
module tb_router_pkt_reg;

    localparam int DW = 8;
    localparam int SD = 2;

    logic          clock = 1'b0;
    logic          resetn = 1'b0;
    logic          i_pkt_valid;
    logic [DW-1:0] i_data_in;
    logic          i_fifo_full;
    logic          i_detect_add;
    logic          i_lfd_state;
    logic          i_ld_state;
    logic          i_laf_state;
    logic          i_rst_int_reg;
    logic [DW-1:0] o_dout;
    logic          o_dout_wr;
    logic          o_skid_empty;
    logic [1:0]    o_skid_count;
    logic          o_low_pkt_valid;
    logic          o_parity_done;
    logic          o_err;
    logic          o_len_err;
    logic          o_ovf_err;

    router_pkt_reg #(.DW(DW), .SKID_DEPTH(SD)) u_dut (
        .clock          (clock),
        .resetn         (resetn),
        .i_pkt_valid    (i_pkt_valid),
        .i_data_in      (i_data_in),
        .i_fifo_full    (i_fifo_full),
        .i_detect_add   (i_detect_add),
        .i_lfd_state    (i_lfd_state),
        .i_ld_state     (i_ld_state),
        .i_laf_state    (i_laf_state),
        .i_rst_int_reg  (i_rst_int_reg),
        .o_dout         (o_dout),
        .o_dout_wr      (o_dout_wr),
        .o_skid_empty   (o_skid_empty),
        .o_skid_count   (o_skid_count),
        .o_low_pkt_valid(o_low_pkt_valid),
        .o_parity_done  (o_parity_done),
        .o_err          (o_err),
        .o_len_err      (o_len_err),
        .o_ovf_err      (o_ovf_err)
    );

    always #5 clock = ~clock;

    logic [7:0] sb [$];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] pay [0:7];
    int         npay;
    logic [8:0] fullmask;
    logic       exp_err = 1'b0;
    logic       exp_len = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        i_pkt_valid   = 1'b0;
        i_data_in     = '0;
        i_fifo_full   = 1'b0;
        i_detect_add  = 1'b0;
        i_lfd_state   = 1'b0;
        i_ld_state    = 1'b0;
        i_laf_state   = 1'b0;
        i_rst_int_reg = 1'b0;
    endtask

    // One clock; outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clock);
        #1;
        if (o_dout_wr) begin
            if (sb.size() == 0) begin
                check_val("dout_wr_unexpected", 32'(o_dout_wr), 32'd0);
            end else begin
                check_val("dout", 32'(o_dout), 32'(sb.pop_front()));
            end
        end
    endtask

    // Drives one complete packet as the router FSM would, predicting the
    // skid occupancy, drops, parity and length outcome along the way.
    task automatic send_pkt(input logic [7:0] hdr, input logic [7:0] par);
        int         occ;
        int         ndrain;
        logic [7:0] xp;
        logic [7:0] pp;
        logic [5:0] cnt;
        logic       ovf;
        logic       pdone;
        logic       par_acc;
        logic [7:0] b;
        logic       lst;
        logic       fl;
        xp = hdr; pp = 8'h00; cnt = 6'd0; occ = 0; ovf = 1'b0;
        pdone = 1'b0; par_acc = 1'b0;

        idle_inputs();
        i_detect_add = 1'b1; i_pkt_valid = 1'b1; i_data_in = hdr;
        step();
        check_val("ovf_after_detect", 32'(o_ovf_err), 32'd0);
        check_val("pdone_after_detect", 32'(o_parity_done), 32'd0);
        check_val("err_kept_on_detect", 32'(o_err), 32'(exp_err));

        idle_inputs();
        i_lfd_state = 1'b1; i_pkt_valid = 1'b1; i_data_in = 8'hA5;
        sb.push_back(hdr);
        step();

        for (int i = 0; i <= npay; i++) begin
            lst = (i == npay);
            b   = lst ? par : pay[i];
            fl  = fullmask[i];
            idle_inputs();
            i_ld_state = 1'b1; i_pkt_valid = !lst; i_data_in = b; i_fifo_full = fl;
            if (fl && occ == SD) begin
                ovf = 1'b1;
            end else begin
                sb.push_back(b);
                if (lst) begin
                    pp = b;
                    par_acc = 1'b1;
                    if (!fl && occ == 0) pdone = 1'b1;
                end else begin
                    xp ^= b;
                    cnt++;
                end
                if (fl) occ++;
            end
            step();
            check_val("skid_count", 32'(o_skid_count), 32'(occ));
            check_val("ovf_err", 32'(o_ovf_err), 32'(ovf));
        end
        check_val("pdone_direct", 32'(o_parity_done), 32'(pdone));
        check_val("low_pkt_valid_set", 32'(o_low_pkt_valid), 32'd1);

        ndrain = occ;
        for (int k = 0; k < ndrain; k++) begin
            idle_inputs();
            i_laf_state = 1'b1;
            step();
            occ--;
            check_val("drain_count", 32'(o_skid_count), 32'(occ));
        end
        idle_inputs();
        check_val("skid_empty", 32'(o_skid_empty), 32'd1);
        check_val("parity_done", 32'(o_parity_done), 32'(par_acc));

        exp_err = (xp != pp);
        exp_len = (cnt != hdr[7:2]);
        i_rst_int_reg = 1'b1;
        step();
        idle_inputs();
        check_val("err", 32'(o_err), 32'(exp_err));
        check_val("len_err", 32'(o_len_err), 32'(exp_len));
        check_val("low_pkt_valid_clr", 32'(o_low_pkt_valid), 32'd0);
        check_val("ovf_hold", 32'(o_ovf_err), 32'(ovf));
        check_val("sb_drained", 32'(sb.size()), 32'd0);
        step();
    endtask

    task automatic load3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        pay[0] = a; pay[1] = b; pay[2] = c; npay = 3;
    endtask

    initial begin
        idle_inputs();
        fullmask = '0;
        resetn = 1'b0;
        step();
        step();
        check_val("rst_dout", 32'(o_dout), 32'd0);
        check_val("rst_dout_wr", 32'(o_dout_wr), 32'd0);
        check_val("rst_skid_empty", 32'(o_skid_empty), 32'd1);
        check_val("rst_skid_count", 32'(o_skid_count), 32'd0);
        check_val("rst_flags", 32'({o_low_pkt_valid, o_parity_done, o_err, o_len_err, o_ovf_err}), 32'd0);
        resetn = 1'b1;
        step();

        // Clean packet
        load3(8'h11, 8'h22, 8'h33); fullmask = 9'b0;
        send_pkt(8'h0D, 8'h0D);
        // Bad parity, then error persists while idle
        send_pkt(8'h0D, 8'h0E);
        step(); step();
        check_val("err_sticky", 32'(o_err), 32'd1);
        // Good packet clears the error
        send_pkt(8'h0D, 8'h0D);
        // Short payload
        pay[0] = 8'h11; pay[1] = 8'h22; npay = 2; fullmask = 9'b0;
        send_pkt(8'h0D, 8'h0D);
        // FIFO full during 0x22 and 0x33
        load3(8'h11, 8'h22, 8'h33); fullmask = 9'b000000110;
        send_pkt(8'h0D, 8'h0D);
        // FIFO full during all three payload bytes: third one dropped
        load3(8'h11, 8'h22, 8'h33); fullmask = 9'b000000111;
        send_pkt(8'h0D, 8'h0D);
        // Different header/payload pattern with backlog at the parity byte
        pay[0] = 8'hF0; pay[1] = 8'h5A; pay[2] = 8'h3C; pay[3] = 8'h81; npay = 4;
        fullmask = 9'b000011000;
        send_pkt(8'h12, 8'h3B);

        // Reset mid-payload with one byte parked in the skid
        load3(8'h11, 8'h22, 8'h33); fullmask = 9'b000000111;
        send_pkt(8'h0D, 8'h0D);
        idle_inputs();
        i_detect_add = 1'b1; i_pkt_valid = 1'b1; i_data_in = 8'h0D;
        step();
        check_val("ovf_clr_detect", 32'(o_ovf_err), 32'd0);
        idle_inputs();
        i_lfd_state = 1'b1; i_pkt_valid = 1'b1;
        sb.push_back(8'h0D);
        step();
        idle_inputs();
        i_ld_state = 1'b1; i_pkt_valid = 1'b1; i_data_in = 8'h11;
        sb.push_back(8'h11);
        step();
        i_data_in = 8'h22; i_fifo_full = 1'b1;
        step();
        check_val("pre_rst_count", 32'(o_skid_count), 32'd1);
        idle_inputs();
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        check_val("mid_rst_dout", 32'(o_dout), 32'd0);
        check_val("mid_rst_dout_wr", 32'(o_dout_wr), 32'd0);
        check_val("mid_rst_skid_empty", 32'(o_skid_empty), 32'd1);
        check_val("mid_rst_skid_count", 32'(o_skid_count), 32'd0);
        check_val("mid_rst_flags", 32'({o_low_pkt_valid, o_parity_done, o_err, o_len_err, o_ovf_err}), 32'd0);
        check_val("mid_rst_sb", 32'(sb.size()), 32'd0);
        sb.delete();
        exp_err = 1'b0; exp_len = 1'b0;
        step();
        load3(8'h11, 8'h22, 8'h33); fullmask = 9'b0;
        send_pkt(8'h0D, 8'h0D);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
